char_buf_writer: RTL and testbench

CHAR_BUF_WRITER -- requirements
Module: char_buf_writer

---
 rtl/char_buf_writer.sv | 117 +++++++++++
 tb/tb_char_buf_writer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/char_buf_writer.sv
// Streams UDP payload characters into a char-buffer RAM and commits the frame
// length as two bytes at STRLENDATA_SAVED_ADDR once the frame ends cleanly.
module char_buf_writer #(
  parameter int STRLENDATA_SAVED_ADDR  = 1023,
  parameter int CHAR_BUFFER_ADDR_WIDTH = 12
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic [7:0]                        s_data,
  input  logic                              s_valid,
  input  logic                              s_last,
  input  logic                              s_abort,
  output logic                              s_ready,
  output logic [CHAR_BUFFER_ADDR_WIDTH-1:0] ram_waddr,
  output logic [7:0]                        ram_wdata,
  output logic                              ram_wen,
  output logic                              frame_done,
  output logic                              frame_overflow,
  output logic [15:0]                       char_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLR_HI = 3'd1,
    S_CLR_LO = 3'd2,
    S_RECV   = 3'd3,
    S_LEN_HI = 3'd4,
    S_LEN_LO = 3'd5
  } state_t;

  localparam logic [CHAR_BUFFER_ADDR_WIDTH-1:0] LEN_HI_ADDR =
    CHAR_BUFFER_ADDR_WIDTH'(STRLENDATA_SAVED_ADDR);
  localparam logic [CHAR_BUFFER_ADDR_WIDTH-1:0] LEN_LO_ADDR =
    CHAR_BUFFER_ADDR_WIDTH'(STRLENDATA_SAVED_ADDR + 1);
  localparam logic [15:0] WCNT_MAX = 16'(STRLENDATA_SAVED_ADDR);

  state_t      state_r;
  logic [15:0] wcnt_r;

  assign s_ready = (state_r == S_RECV);

  // Frame FSM; the length is zeroed before the payload is rewritten so a reader never sees a stale length
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r        <= S_IDLE;
      wcnt_r         <= 16'd0;
      ram_wen        <= 1'b0;
      ram_waddr      <= '0;
      ram_wdata      <= 8'h00;
      frame_done     <= 1'b0;
      frame_overflow <= 1'b0;
      char_count     <= 16'd0;
    end else begin
      ram_wen    <= 1'b0;
      frame_done <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (s_valid) begin
            wcnt_r         <= 16'd0;
            frame_overflow <= 1'b0;
            state_r        <= S_CLR_HI;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_CLR_HI: begin
          ram_wen   <= 1'b1;
          ram_waddr <= LEN_HI_ADDR;
          ram_wdata <= 8'h00;
          state_r   <= S_CLR_LO;
        end
        S_CLR_LO: begin
          ram_wen   <= 1'b1;
          ram_waddr <= LEN_LO_ADDR;
          ram_wdata <= 8'h00;
          state_r   <= S_RECV;
        end
        S_RECV: begin
          if (s_valid && s_abort) begin
            state_r <= S_IDLE;
          end else if (s_valid) begin
            // Bytes beyond the buffer are dropped but the frame still completes
            if (wcnt_r < WCNT_MAX) begin
              ram_wen   <= 1'b1;
              ram_waddr <= CHAR_BUFFER_ADDR_WIDTH'(wcnt_r);
              ram_wdata <= s_data;
              wcnt_r    <= wcnt_r + 16'd1;
            end else begin
              frame_overflow <= 1'b1;
            end
            state_r <= s_last ? S_LEN_HI : S_RECV;
          end else begin
            state_r <= S_RECV;
          end
        end
        S_LEN_HI: begin
          ram_wen   <= 1'b1;
          ram_waddr <= LEN_HI_ADDR;
          ram_wdata <= wcnt_r[15:8];
          state_r   <= S_LEN_LO;
        end
        S_LEN_LO: begin
          ram_wen    <= 1'b1;
          ram_waddr  <= LEN_LO_ADDR;
          ram_wdata  <= wcnt_r[7:0];
          char_count <= wcnt_r;
          frame_done <= 1'b1;
          state_r    <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_char_buf_writer.sv
// Directed bench for char_buf_writer: table-driven frames plus hand-written
// overflow, abort, mid-frame reset and back-to-back sequences.
module tb_char_buf_writer;
  localparam int AW = 12;
  localparam int P  = 1023;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [7:0]    s_data = 8'h00;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic          s_abort = 1'b0;
  logic          s_ready;
  logic [AW-1:0] ram_waddr;
  logic [7:0]    ram_wdata;
  logic          ram_wen;
  logic          frame_done;
  logic          frame_overflow;
  logic [15:0]   char_count;

  char_buf_writer #(.STRLENDATA_SAVED_ADDR(P), .CHAR_BUFFER_ADDR_WIDTH(AW)) dut (
    .clk(clk), .resetn(resetn), .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_abort(s_abort), .s_ready(s_ready),
    .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_wen(ram_wen),
    .frame_done(frame_done), .frame_overflow(frame_overflow),
    .char_count(char_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [7:0]    d;
    int            c;
  } wr_t;

  typedef struct {
    string txt;
    bit    gaps;
    int    exp_len;
  } vec_t;

  wr_t log_q[$];
  wr_t exp_q[$];
  int  acc_q[$];
  int  cyc = 0;
  int  done_cnt = 0;
  int  n_cmp = 0;
  int  n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM write and frame_done monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (ram_wen === 1'b1) log_q.push_back('{ram_waddr, ram_wdata, cyc});
    if (frame_done === 1'b1) done_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic void push_exp(input int a, input logic [7:0] d);
    exp_q.push_back('{AW'(a), d, 0});
  endfunction

  function automatic void exp_frame(input logic [7:0] dq[$], input bit with_len);
    int n;
    n = (dq.size() > P) ? P : dq.size();
    push_exp(P, 8'h00);
    push_exp(P + 1, 8'h00);
    for (int i = 0; i < n; i++) push_exp(i, dq[i]);
    if (with_len) begin
      push_exp(P, 8'(n >> 8));
      push_exp(P + 1, 8'(n & 255));
    end
  endfunction

  task automatic check_log(input string nm, input int lstart);
    int n;
    chk({nm, "_nwrites"}, 32'(log_q.size() - lstart), 32'(exp_q.size()));
    n = ((log_q.size() - lstart) < exp_q.size()) ? (log_q.size() - lstart) : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({nm, "_addr"}, 32'(log_q[lstart+i].a), 32'(exp_q[i].a));
      chk({nm, "_data"}, 32'(log_q[lstart+i].d), 32'(exp_q[i].d));
    end
    exp_q.delete();
  endtask

  task automatic drive(input logic [7:0] dq[$], input bit lq[$], input int abort_at, input bit gaps);
    bit ok;
    for (int i = 0; i < dq.size(); i++) begin
      if (gaps) begin
        s_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
      s_valid = 1'b1;
      s_data  = dq[i];
      s_last  = lq[i];
      s_abort = (i == abort_at);
      ok = 1'b0;
      for (int t = 0; t < 50 && !ok; t++) begin
        @(negedge clk);
        if (s_ready === 1'b1) begin
          acc_q.push_back(cyc);
          ok = 1'b1;
        end
        @(posedge clk);
        #1;
      end
      if (!ok) begin
        chk("beat_accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_abort = 1'b0;
  endtask

  task automatic settle();
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t        vecs[3];
    logic [7:0]  dq[$];
    bit          lq[$];
    int          lstart, astart, dstart;

    #1_000_000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[3];
    logic [7:0]  dq[$];
    bit          lq[$];
    int          lstart, astart, dstart;

    vecs[0] = '{"HELLO", 1'b0, 5};
    vecs[1] = '{"A\015\012B", 1'b1, 4};
    vecs[2] = '{" \012\015 ", 1'b0, 4};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ram_wen", 32'(ram_wen), 32'd0);
    chk("rst_ram_waddr", 32'(ram_waddr), 32'd0);
    chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_overflow", 32'(frame_overflow), 32'd0);
    chk("rst_char_count", 32'(char_count), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven single frames
    for (int v = 0; v < 3; v++) begin
      dq.delete(); lq.delete();
      for (int i = 0; i < vecs[v].txt.len(); i++) begin
        dq.push_back(vecs[v].txt[i]);
        lq.push_back(i == vecs[v].txt.len() - 1);
      end
      lstart = log_q.size(); astart = acc_q.size(); dstart = done_cnt;
      drive(dq, lq, -1, vecs[v].gaps);
      settle();
      exp_frame(dq, 1'b1);
      if (vecs[v].gaps) begin
        for (int i = 0; i < dq.size() && lstart + 2 + i < log_q.size(); i++)
          chk("beat_to_write_latency", 32'(log_q[lstart+2+i].c), 32'(acc_q[astart+i] + 1));
      end
      check_log("frame", lstart);
      chk("frame_char_count", 32'(char_count), 32'(vecs[v].exp_len));
      chk("frame_done_pulses", 32'(done_cnt - dstart), 32'd1);
      chk("frame_overflow", 32'(frame_overflow), 32'd0);
    end

    // Oversized frame is truncated at the buffer limit
    dq.delete(); lq.delete();
    for (int i = 0; i < 1100; i++) begin
      dq.push_back(8'(i * 7 + 3));
      lq.push_back(i == 1099);
    end
    lstart = log_q.size(); dstart = done_cnt;
    drive(dq, lq, -1, 1'b0);
    settle();
    exp_frame(dq, 1'b1);
    check_log("ovf", lstart);
    chk("ovf_overflow", 32'(frame_overflow), 32'd1);
    chk("ovf_char_count", 32'(char_count), 32'd1023);
    chk("ovf_done_pulses", 32'(done_cnt - dstart), 32'd1);

    // Abort on the fourth byte
    dq.delete(); lq.delete();
    for (int i = 0; i < 4; i++) begin
      dq.push_back(8'(8'h30 + i));
      lq.push_back(1'b0);
    end
    lstart = log_q.size(); dstart = done_cnt;
    drive(dq, lq, 3, 1'b0);
    settle();
    dq.pop_back();
    exp_frame(dq, 1'b0);
    check_log("abort", lstart);
    chk("abort_done_pulses", 32'(done_cnt - dstart), 32'd0);
    chk("abort_idle_s_ready", 32'(s_ready), 32'd0);
    chk("abort_char_count_kept", 32'(char_count), 32'd1023);

    // Reset in the middle of a frame
    dq = '{8'h61, 8'h62, 8'h63};
    lq = '{1'b0, 1'b0, 1'b0};
    lstart = log_q.size();
    drive(dq, lq, -1, 1'b0);
    @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk);
    #1;
    chk("mrst_ram_wen", 32'(ram_wen), 32'd0);
    chk("mrst_ram_waddr", 32'(ram_waddr), 32'd0);
    chk("mrst_ram_wdata", 32'(ram_wdata), 32'd0);
    chk("mrst_frame_done", 32'(frame_done), 32'd0);
    chk("mrst_overflow", 32'(frame_overflow), 32'd0);
    chk("mrst_char_count", 32'(char_count), 32'd0);
    chk("mrst_s_ready", 32'(s_ready), 32'd0);
    resetn = 1'b1;
    settle();
    chk("mrst_idle_s_ready", 32'(s_ready), 32'd0);
    exp_frame(dq, 1'b0);
    check_log("mrst", lstart);

    dq = '{8'h58, 8'h59};
    lq = '{1'b0, 1'b1};
    lstart = log_q.size(); dstart = done_cnt;
    drive(dq, lq, -1, 1'b0);
    settle();
    exp_frame(dq, 1'b1);
    check_log("xy", lstart);
    chk("xy_char_count", 32'(char_count), 32'd2);
    chk("xy_overflow", 32'(frame_overflow), 32'd0);
    chk("xy_done_pulses", 32'(done_cnt - dstart), 32'd1);

    // Two back-to-back frames with s_valid held across the boundary
    dq = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36};
    lq = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    lstart = log_q.size(); dstart = done_cnt;
    drive(dq, lq, -1, 1'b0);
    settle();
    exp_frame('{8'h31, 8'h32, 8'h33}, 1'b1);
    exp_frame('{8'h34, 8'h35, 8'h36}, 1'b1);
    check_log("b2b", lstart);
    chk("b2b_done_pulses", 32'(done_cnt - dstart), 32'd2);
    chk("b2b_char_count", 32'(char_count), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
